// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: execution controller for the single-cycle demo CPU.
// Turns a run switch and a bouncy step button into one-cycle clock-enable pulses,
// halts on a program-counter breakpoint and counts retired instructions.
//
// Optional feature macro: CPU_STEP_CTRL_BREAKPOINT_EN (breakpoint compare + BREAK state).
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   run_sw   - raw run switch (1 = run), asynchronous
//   step_btn - raw step push-button (1 = pressed), asynchronous, bouncy
//   pc       - current CPU program counter
//   bp_addr  - breakpoint address
//   cpu_ce   - registered CPU clock-enable pulses
//   halted   - high whenever state is not RUN
//   state    - 0 = HALT, 1 = RUN, 2 = BREAK
//   retired  - count of issued cpu_ce pulses (wraps)
module cpu_step_ctrl #(
  parameter int unsigned PORT_WIDTH      = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RUN_DIV         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_sw,
  input  logic                  step_btn,
  input  logic [PORT_WIDTH-1:0] pc,
  input  logic [PORT_WIDTH-1:0] bp_addr,
  output logic                  cpu_ce,
  output logic                  halted,
  output logic [1:0]            state,
  output logic [15:0]           retired
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PrescW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StBreak = 2'd2
  } state_e;

  // Index 0 = run switch, index 1 = step button.
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           deb_q, deb_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic                 step_prev_q, press_q;

  state_e               state_q, state_d;
  logic                 ce_q, ce_d;
  logic [PrescW-1:0]    presc_q, presc_d;
  logic                 entry_q, entry_d;
  logic [15:0]          retired_q;
  logic                 bp_hit;
  logic                 run_deb;

`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
  assign bp_hit = (pc == bp_addr);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc, bp_addr};
  assign bp_hit = 1'b0;
`endif

  assign run_deb = deb_q[0];

  // Debouncers: counter runs while synced differs from debounced, and the new level
  // is accepted once the counter has reached DEBOUNCE_CYCLES.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES)) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    presc_d = presc_q;
    entry_d = 1'b0;
    unique case (state_q)
      StHalt: begin
        presc_d = '0;
        if (run_deb) begin
          state_d = StRun;
          entry_d = 1'b1;
        end else if (press_q) begin
          ce_d = 1'b1;
        end
      end
      StRun: begin
        if (!run_deb) begin
          state_d = StHalt;
          presc_d = '0;
        end else if (entry_q) begin
          // First RUN cycle only clears the prescaler; decisions start next cycle.
          presc_d = '0;
        end else if (presc_q == PrescW'(RUN_DIV - 1)) begin
          presc_d = '0;
          if (bp_hit) begin
            state_d = StBreak;
          end else begin
            ce_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StBreak: begin
        presc_d = '0;
        if (!run_deb) begin
          state_d = StHalt;
        end else if (press_q) begin
          ce_d    = 1'b1;
          state_d = StRun;
          entry_d = 1'b1;
        end
      end
      default: begin
        state_d = StHalt;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
      press_q     <= 1'b0;
      state_q     <= StHalt;
      ce_q        <= 1'b0;
      presc_q     <= '0;
      entry_q     <= 1'b0;
      retired_q   <= '0;
    end else begin
      sync1_q     <= {step_btn, run_sw};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      step_prev_q <= deb_q[1];
      press_q     <= deb_q[1] & ~step_prev_q;
      state_q     <= state_d;
      ce_q        <= ce_d;
      presc_q     <= presc_d;
      entry_q     <= entry_d;
      if (ce_q) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign cpu_ce  = ce_q;
  assign state   = state_q;
  assign halted  = (state_q != StRun);
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl.
// Main instance: DEBOUNCE_CYCLES=16, RUN_DIV=4. Second instance: DEBOUNCE_CYCLES=1,
// RUN_DIV=1, used for the continuous-enable and counter-wrap checks.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_sw, step_btn;
  logic [9:0]  pc_m, bp_addr;
  logic        cpu_ce, halted;
  logic [1:0]  state;
  logic [15:0] retired;

  logic        run_f, step_f;
  logic [9:0]  pc_f, bp_f;
  logic        cpu_ce_f, halted_f;
  logic [1:0]  state_f;
  logic [15:0] retired_f;

  logic        pc_clr;
  int          ce_cnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .PORT_WIDTH(10), .DEBOUNCE_CYCLES(16), .RUN_DIV(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn), .pc(pc_m),
    .bp_addr(bp_addr), .cpu_ce(cpu_ce), .halted(halted), .state(state), .retired(retired)
  );

  cpu_step_ctrl #(
    .PORT_WIDTH(10), .DEBOUNCE_CYCLES(1), .RUN_DIV(1)
  ) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .run_sw(run_f), .step_btn(step_f), .pc(pc_f),
    .bp_addr(bp_f), .cpu_ce(cpu_ce_f), .halted(halted_f), .state(state_f),
    .retired(retired_f)
  );

  // CPU model: pc advances once per enable pulse; pulse counter for the main instance.
  always @(posedge clk) begin
    if (pc_clr) pc_m <= '0;
    else if (cpu_ce) pc_m <= pc_m + 10'd1;
    if (cpu_ce) ce_cnt <= ce_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int c0, lat, last, low_cnt;
    bit seen;
    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; bp_addr = 10'h3FF; pc_clr = 1'b0;
    run_f = 1'b0; step_f = 1'b0; pc_f = '0; bp_f = 10'h3FF;
    pc_m = '0; ce_cnt = 0;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clean press: pulse lands 20 cycles after the first sampling edge.
    c0 = ce_cnt; lat = 0; seen = 1'b0;
    step_btn = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (cpu_ce && !seen) begin lat = k; seen = 1'b1; end
    end
    check("step_latency", 32'(lat), 32'd21);
    check("step_one_pulse", 32'(ce_cnt - c0), 32'd1);
    check("step_retired", 32'(retired), 32'd1);
    check("step_state", 32'(state), 32'd0);
    step_btn = 1'b0;
    repeat (30) tick();

    // Bouncy press then long hold.
    c0 = ce_cnt;
    for (int t = 0; t < 10; t++) begin
      step_btn = (t % 2 == 0);
      repeat (3) tick();
    end
    step_btn = 1'b1;
    repeat (100) tick();
    check("bouncy_one_pulse", 32'(ce_cnt - c0), 32'd1);
    check("bouncy_retired", 32'(retired), 32'd2);
    step_btn = 1'b0;
    repeat (30) tick();
    step_btn = 1'b1;
    repeat (40) tick();
    check("second_press_retired", 32'(retired), 32'd3);
    step_btn = 1'b0;
    repeat (30) tick();

    // Priority: step press and debounced run rise land in the same HALT cycle.
    c0 = ce_cnt;
    step_btn = 1'b1;
    tick();
    run_sw = 1'b1;
    repeat (19) tick();
    check("prio_still_halt", 32'(state), 32'd0);
    tick();
    check("prio_state_run", 32'(state), 32'd1);
    check("prio_halted_low", 32'(halted), 32'd0);
    repeat (4) tick();
    check("prio_no_extra_pulse", 32'(ce_cnt - c0), 32'd0);
    check("prio_ce_low", 32'(cpu_ce), 32'd0);
    tick();
    check("run_first_pulse", 32'(cpu_ce), 32'd1);
    step_btn = 1'b0;

    // Run cadence: pulses exactly RUN_DIV cycles apart.
    last = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cpu_ce) begin
        if (last >= 0) check("run_gap", 32'(i - last), 32'd4);
        last = i;
      end
    end
    check("run_state_held", 32'(state), 32'd1);

    // Drop run: halts after debounce, then no more pulses.
    run_sw = 1'b0;
    repeat (21) tick();
    check("drop_state", 32'(state), 32'd0);
    check("drop_halted", 32'(halted), 32'd1);
    c0 = ce_cnt;
    repeat (40) tick();
    check("drop_no_pulses", 32'(ce_cnt - c0), 32'd0);

    // Breakpoint at 5 with pc counting from 0.
    pc_clr = 1'b1;
    tick();
    pc_clr = 1'b0;
    bp_addr = 10'h005;
    c0 = ce_cnt;
    run_sw = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (state == 2'd1) seen = 1'b1;
    end
    check("bp_enter_run", 32'(seen), 32'd1);
    repeat (40) tick();
`ifdef CPU_STEP_CTRL_BREAKPOINT_EN
    check("bp_pulses", 32'(ce_cnt - c0), 32'd5);
    check("bp_state", 32'(state), 32'd2);
    check("bp_ce_low", 32'(cpu_ce), 32'd0);
    check("bp_pc", 32'(pc_m), 32'd5);
    c0 = ce_cnt;
    step_btn = 1'b1;
    repeat (22) tick();
    check("bp_step_pulse", 32'(ce_cnt - c0), 32'd1);
    check("bp_step_state", 32'(state), 32'd1);
`else
    check("nobp_pulses", 32'(ce_cnt - c0), 32'd9);
    check("nobp_state", 32'(state), 32'd1);
    check("nobp_pc", 32'(pc_m), 32'd9);
`endif
    step_btn = 1'b0;

    // Asynchronous reset while a pulse is high.
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (cpu_ce) seen = 1'b1;
      else tick();
    end
    check("rst_mid_seen_pulse", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_ce", 32'(cpu_ce), 32'd0);
    check("rstmid_state", 32'(state), 32'd0);
    check("rstmid_halted", 32'(halted), 32'd1);
    check("rstmid_retired", 32'(retired), 32'd0);
    run_sw = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("rstmid_stays_halt", 32'(state), 32'd0);

    // Wrap: RUN_DIV=1 gives continuous enable; 65536 pulses wrap the count to 0.
    run_f = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (cpu_ce_f) seen = 1'b1;
    end
    check("wrap_start", 32'(seen), 32'd1);
    check("wrap_retired0", 32'(retired_f), 32'd0);
    low_cnt = 0;
    for (int k = 0; k < 65535; k++) begin
      tick();
      if (!cpu_ce_f) low_cnt++;
    end
    check("wrap_continuous", 32'(low_cnt), 32'd0);
    check("wrap_ffff", 32'(retired_f), 32'h0000_FFFF);
    tick();
    check("wrap_zero", 32'(retired_f), 32'd0);
    check("wrap_ce_high", 32'(cpu_ce_f), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
